// File: rtl/silife_wb_loader.sv
// Wishbone initiator that stops the Silife grid, loads or dumps every matrix row,
// and (after a load) restarts evolution with the requested CTRL value.
module silife_wb_loader #(
    parameter int          WIDTH     = 8,
    parameter int          HEIGHT    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic             cmd_mode,
    input  logic [2:0]       cmd_ctrl,
    input  logic [WIDTH-1:0] row_data,
    input  logic             row_valid,
    output logic             row_ready,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_valid,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [31:0]      o_wb_addr,
    output logic [31:0]      o_wb_data,
    input  logic             i_wb_ack,
    input  logic [31:0]      i_wb_data
);

    localparam int CW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_ROW  = CW'(HEIGHT - 1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT);
    localparam logic [31:0]   CTRL_ADDR = BASE_ADDR;
    localparam logic [31:0]   ROW_BASE  = BASE_ADDR + 32'h1000;

    typedef enum logic [2:0] {
        IDLE, STOP, ROW_WAIT, ROW_XFER, START, DONE, ERROR
    } state_t;

    state_t          state;
    logic            mode;
    logic [2:0]      ctrl;
    logic [CW-1:0]   row_cnt;
    logic [31:0]     row_buf;
    logic [TW-1:0]   to_cnt;

    logic            launch_we;
    logic [31:0]     launch_addr;
    logic [31:0]     launch_data;

    // Only the low WIDTH bits of read data are consumed.
    logic unused_rdata;
    assign unused_rdata = ^i_wb_data;

    assign row_ready = (state == ROW_WAIT);

    // Request presented when the bus states open a new transaction.
    always_comb begin
        launch_we   = 1'b0;
        launch_addr = CTRL_ADDR;
        launch_data = '0;
        case (state)
            STOP: begin
                launch_we   = 1'b1;
                launch_addr = CTRL_ADDR;
                launch_data = '0;
            end
            ROW_XFER: begin
                launch_we   = ~mode;
                launch_addr = ROW_BASE + (32'(row_cnt) << 2);
                launch_data = mode ? '0 : row_buf;
            end
            START: begin
                launch_we   = 1'b1;
                launch_addr = CTRL_ADDR;
                launch_data = {29'b0, ctrl};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mode       <= 1'b0;
            ctrl       <= '0;
            row_cnt    <= '0;
            row_buf    <= '0;
            to_cnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_addr  <= '0;
            o_wb_data  <= '0;
        end else begin
            done       <= 1'b0;
            error      <= 1'b0;
            dump_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        mode    <= cmd_mode;
                        ctrl    <= cmd_ctrl;
                        row_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= STOP;
                    end
                end
                ROW_WAIT: begin
                    if (row_valid) begin
                        row_buf <= 32'(row_data);
                        state   <= ROW_XFER;
                    end
                end
                // Bus states: open a transaction while cyc is low, then wait for
                // ack or timeout. cyc drops on completion, so the next bus state
                // always sees one idle cycle before it launches.
                STOP, ROW_XFER, START: begin
                    if (!o_wb_cyc) begin
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= launch_we;
                        o_wb_addr <= launch_addr;
                        o_wb_data <= launch_data;
                        to_cnt    <= '0;
                    end else if (i_wb_ack) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        case (state)
                            STOP:  state <= mode ? ROW_XFER : ROW_WAIT;
                            START: state <= DONE;
                            default: begin
                                if (mode) begin
                                    dump_data  <= i_wb_data[WIDTH-1:0];
                                    dump_valid <= 1'b1;
                                end
                                if (row_cnt == LAST_ROW) begin
                                    state <= mode ? DONE : START;
                                end else begin
                                    row_cnt <= row_cnt + 1'b1;
                                    state   <= mode ? ROW_XFER : ROW_WAIT;
                                end
                            end
                        endcase
                    end else if (to_cnt == TO_LIMIT) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        state    <= ERROR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERROR: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
